// File: rtl/aes_round_key_store.sv
`default_nettype none
// ============================================================================
// Module : aes_round_key_store
// Brief  : Drives an external AES-128 key generator and stores the NROUND+1
//          round keys it produces; serves registered single-cycle reads.
// Rev    : 1.0
// ============================================================================
module aes_round_key_store #(
  parameter int NROUND = 10
) (
  input  logic         pClk,
  input  logic         sRst,
  input  logic         start,
  input  logic [127:0] aesKey,
  output logic [127:0] kgKey,
  output logic         kgEnable,
  output logic         kgLoadKey,
  output logic [3:0]   kgRoundCount,
  input  logic [127:0] kgRoundKey,
  output logic         keyBusy,
  output logic         keyValid,
  input  logic         rdReq,
  input  logic [3:0]   rdIdx,
  output logic [127:0] rdData,
  output logic         rdValid,
  output logic         rdErr
);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_EXPAND = 2'd1;
  localparam logic [1:0] c_READY  = 2'd2;
  localparam logic [3:0] c_LAST   = 4'(NROUND);

  logic [1:0]   r_state;
  logic [3:0]   r_cnt;
  logic [127:0] r_key;
  logic [127:0] r_slot [0:NROUND];
  logic [127:0] r_rd_data;
  logic         r_rd_valid;
  logic         r_rd_err;

  logic w_expand;
  logic w_rd_ok;

  assign w_expand = (r_state == c_EXPAND);
  // Reads see the pre-edge schedule, so a start coinciding with a read returns old data.
  assign w_rd_ok  = (r_state == c_READY) && (rdIdx <= c_LAST);

  assign kgKey        = r_key;
  assign kgEnable     = w_expand && (r_cnt < c_LAST);
  assign kgLoadKey    = w_expand && (r_cnt == 4'd0);
  assign kgRoundCount = w_expand ? r_cnt : 4'd0;
  assign keyBusy      = w_expand;
  assign keyValid     = (r_state == c_READY);
  assign rdData       = r_rd_data;
  assign rdValid      = r_rd_valid;
  assign rdErr        = r_rd_err;

  always_ff @(posedge pClk) begin
    if (sRst) begin
      r_state    <= c_IDLE;
      r_cnt      <= 4'd0;
      r_key      <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
      for (int i = 0; i <= NROUND; i++) begin
        r_slot[i] <= '0;
      end
    end else begin
      r_rd_valid <= rdReq;
      r_rd_err   <= rdReq && !w_rd_ok;
      r_rd_data  <= (rdReq && w_rd_ok) ? r_slot[rdIdx] : '0;

      case (r_state)
        c_IDLE, c_READY: begin
          if (start) begin
            r_key     <= aesKey;
            r_slot[0] <= aesKey;
            r_cnt     <= 4'd0;
            r_state   <= c_EXPAND;
          end
        end
        c_EXPAND: begin
          // The generator output is registered: round key c is visible while cnt == c.
          if (r_cnt != 4'd0) begin
            r_slot[r_cnt] <= kgRoundKey;
          end
          if (r_cnt == c_LAST) begin
            r_cnt   <= 4'd0;
            r_state <= c_READY;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: begin
          r_state <= c_IDLE;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_round_key_store.sv
`default_nettype none
// Bench for aes_round_key_store: behavioural AES-128 key generator plus
// directed expansion timelines and table-driven round-key reads.
module tb_aes_round_key_store;

  logic         pClk = 1'b0;
  logic         sRst, start, rdReq;
  logic [127:0] aesKey;
  logic [3:0]   rdIdx;
  logic [127:0] kgKey, kgRoundKey, rdData;
  logic         kgEnable, kgLoadKey, keyBusy, keyValid, rdValid, rdErr;
  logic [3:0]   kgRoundCount;

  int n_vec = 0;
  int n_bad = 0;

  localparam logic [127:0] KEY1    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY2    = 128'h0f1571c947d9e8590cb7add6af7f6798;
  localparam logic [127:0] KEY3    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_R1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RA = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  aes_round_key_store #(.NROUND(10)) dut (
    .pClk(pClk), .sRst(sRst), .start(start), .aesKey(aesKey),
    .kgKey(kgKey), .kgEnable(kgEnable), .kgLoadKey(kgLoadKey),
    .kgRoundCount(kgRoundCount), .kgRoundKey(kgRoundKey),
    .keyBusy(keyBusy), .keyValid(keyValid), .rdReq(rdReq), .rdIdx(rdIdx),
    .rdData(rdData), .rdValid(rdValid), .rdErr(rdErr)
  );

  always #5 pClk = ~pClk;

  // ---------------- AES-128 key expansion reference ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv = 8'h01;
    logic [7:0] s;
    for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    if (a == 8'h00) inv = 8'h00;
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [127:0] next_rk(input logic [127:0] k, input logic [3:0] c);
    logic [31:0] w3r, t, n0, n1, n2, n3;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 32'(c); i++) rc = xtime(rc);
    w3r = {k[23:0], k[31:24]};
    t   = {sbox(w3r[31:24]) ^ rc, sbox(w3r[23:16]), sbox(w3r[15:8]), sbox(w3r[7:0])};
    n0  = k[127:96] ^ t;
    n1  = k[95:64] ^ n0;
    n2  = k[63:32] ^ n1;
    n3  = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Registered key generator: loadKey selects aesKey, else chains from its own output.
  logic [127:0] kg_rk = '0;
  assign kgRoundKey = kg_rk;
  always @(posedge pClk) begin
    if (kgEnable) kg_rk <= next_rk(kgLoadKey ? kgKey : kg_rk, kgRoundCount);
  end

  logic [127:0] sch [0:10];

  task automatic compute_sched(input logic [127:0] key);
    sch[0] = key;
    for (int i = 1; i <= 10; i++) sch[i] = next_rk(sch[i-1], 4'(i - 1));
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pClk);
    #1;
  endtask

  task automatic chk_zero_state(input string tag);
    chk({tag, "_kgKey"}, kgKey, '0);
    chk({tag, "_keyBusy"}, keyBusy, 0);
    chk({tag, "_keyValid"}, keyValid, 0);
    chk({tag, "_kgEnable"}, kgEnable, 0);
    chk({tag, "_kgLoadKey"}, kgLoadKey, 0);
    chk({tag, "_kgRoundCount"}, kgRoundCount, 0);
    chk({tag, "_rdValid"}, rdValid, 0);
    chk({tag, "_rdErr"}, rdErr, 0);
    chk({tag, "_rdData"}, rdData, '0);
  endtask

  task automatic do_read(input logic [3:0] idx, input logic err, input logic [127:0] data,
                         input string nm);
    rdReq = 1'b1;
    rdIdx = idx;
    tick();
    rdReq = 1'b0;
    chk({nm, "_rdValid"}, rdValid, 1);
    chk({nm, "_rdErr"}, rdErr, err);
    chk({nm, "_rdData"}, rdData, data);
    tick();
    chk({nm, "_idle_rdValid"}, rdValid, 0);
    chk({nm, "_idle_rdData"}, rdData, '0);
  endtask

  // Start at current cycle T and check every cycle up to T+12.
  // A read is issued at T+3 (expansion in progress); optional second start at T+5;
  // optional read coinciding with the start at T.
  task automatic run_expand(input logic [127:0] key, input bit disturb, input bit coinc,
                            input logic [127:0] coinc_data);
    start  = 1'b1;
    aesKey = key;
    if (coinc) begin
      rdReq = 1'b1;
      rdIdx = 4'd0;
    end
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 1) begin
        start  = 1'b0;
        aesKey = ~key;
        rdReq  = 1'b0;
      end
      if (k == 3) begin
        rdReq = 1'b1;
        rdIdx = 4'd2;
      end
      if (k == 4) rdReq = 1'b0;
      if (disturb && k == 5) begin
        start  = 1'b1;
        aesKey = key ^ 128'h5a5a_5a5a;
      end
      if (k == 6) start = 1'b0;
      chk($sformatf("exp_k%0d_keyBusy", k), keyBusy, k <= 11);
      chk($sformatf("exp_k%0d_keyValid", k), keyValid, k == 12);
      chk($sformatf("exp_k%0d_kgLoadKey", k), kgLoadKey, k == 1);
      chk($sformatf("exp_k%0d_kgEnable", k), kgEnable, k <= 10);
      chk($sformatf("exp_k%0d_kgRoundCount", k), kgRoundCount, (k <= 11) ? k - 1 : 0);
      chk($sformatf("exp_k%0d_rdValid", k), rdValid, (k == 4) || (k == 1 && coinc));
      chk($sformatf("exp_k%0d_rdErr", k), rdErr, k == 4);
      chk($sformatf("exp_k%0d_rdData", k), rdData, (k == 1 && coinc) ? coinc_data : '0);
    end
    chk("exp_kgKey", kgKey, key);
  endtask

  typedef struct {
    logic [3:0]   idx;
    logic         err;
    logic [127:0] data;
  } rd_vec_t;

  rd_vec_t vt [0:12];

  // Back-to-back reads of every slot plus two out-of-range indices.
  task automatic run_table(input string tag);
    for (int i = 0; i <= 10; i++) vt[i] = '{idx: 4'(i), err: 1'b0, data: sch[i]};
    vt[11] = '{idx: 4'd11, err: 1'b1, data: '0};
    vt[12] = '{idx: 4'd15, err: 1'b1, data: '0};
    rdReq = 1'b1;
    rdIdx = vt[0].idx;
    for (int i = 0; i <= 12; i++) begin
      tick();
      if (i < 12) rdIdx = vt[i+1].idx;
      else rdReq = 1'b0;
      chk($sformatf("%s_rd%0d_rdValid", tag, vt[i].idx), rdValid, 1);
      chk($sformatf("%s_rd%0d_rdErr", tag, vt[i].idx), rdErr, vt[i].err);
      chk($sformatf("%s_rd%0d_rdData", tag, vt[i].idx), rdData, vt[i].data);
    end
    tick();
    chk({tag, "_after_rdValid"}, rdValid, 0);
    chk({tag, "_after_rdErr"}, rdErr, 0);
    chk({tag, "_after_rdData"}, rdData, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    sRst   = 1'b1;
    start  = 1'b0;
    rdReq  = 1'b0;
    rdIdx  = 4'd0;
    aesKey = '0;
    repeat (3) tick();
    chk_zero_state("reset");
    sRst = 1'b0;
    tick();
    do_read(4'd0, 1'b1, '0, "rd_after_reset");

    // FIPS-197 key, clean expansion
    compute_sched(KEY1);
    run_expand(KEY1, 1'b0, 1'b0, '0);
    run_table("key1");
    do_read(4'd1, 1'b0, FIPS_R1, "fips_rk1");
    do_read(4'd10, 1'b0, FIPS_RA, "fips_rk10");

    // Restart from READY with coincident read of slot 0, and a second start mid-expand
    run_expand(KEY2, 1'b1, 1'b1, KEY1);
    compute_sched(KEY2);
    run_table("key2");

    // Reset in the middle of an expansion, then restart
    start  = 1'b1;
    aesKey = KEY3;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) start = 1'b0;
    end
    sRst = 1'b1;
    tick();
    chk_zero_state("mid_rst");
    sRst = 1'b0;
    tick();
    run_expand(KEY3, 1'b0, 1'b0, '0);
    compute_sched(KEY3);
    run_table("key3");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
